boot_loader_ctrl: RTL and testbench

- Sequences core start-up: holds the single-cycle core in reset, loads a program from a byte stream into instruction memory, then releases the core at a programmed entry PC.
- Sits between an external byte source (UART/debug RX) and the core's imem write port, core reset_n, and init_pc.
- Single controller FSM with a byte assembler, word counter and imem write sequencer.

---
 rtl/boot_loader_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader_ctrl
// Purpose  : Holds the core in reset, loads a little-endian program image
//            from a byte stream into instruction memory, then releases the
//            core at the programmed entry PC.
//            Stream layout: ENTRY, N, N payload words (4 bytes each, LE).
// Options  : CHECKSUM_EN - when defined, a 4-byte trailer carrying the
//            modulo-2^32 sum of the payload words must follow the payload.
// Revision : 1.0 - initial release
// ============================================================================
module boot_loader_ctrl #(
    parameter int WIDTH = 32,
    parameter int IADDR = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             imem_wr_en,
    output logic [IADDR-1:0] imem_wr_addr,
    output logic [WIDTH-1:0] imem_wdata,
    output logic             core_reset_n,
    output logic [WIDTH-1:0] init_pc,
    output logic             busy,
    output logic             error
);

    // Word index width: imem holds 2^(IADDR-2) words.
    localparam int               IDX_W   = IADDR - 2;
    localparam logic [WIDTH-1:0] CAP_W   = WIDTH'(1) << IDX_W;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_PC  = 3'd1,
        ST_HDR_LEN = 3'd2,
        ST_LOAD    = 3'd3,
        ST_RUN     = 3'd4,
        ST_ERR     = 3'd5
`ifdef CHECKSUM_EN
        ,
        ST_CHK     = 3'd6
`endif
    } state_t;

    // State entered once the payload (possibly empty) has been consumed.
`ifdef CHECKSUM_EN
    localparam state_t ST_POST = ST_CHK;
`else
    localparam state_t ST_POST = ST_RUN;
`endif

    state_t             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        asm_q, asm_d;
    logic [WIDTH-1:0]   entry_q, entry_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic               in_ready_q, in_ready_d;
    logic               wr_en_q, wr_en_d;
    logic [IADDR-1:0]   wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               core_reset_n_q, core_reset_n_d;
    logic [WIDTH-1:0]   init_pc_q, init_pc_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;
`ifdef CHECKSUM_EN
    logic [WIDTH-1:0]   sum_q, sum_d;
`endif

    logic               w_accept;
    logic               w_word_done;
    logic [WIDTH-1:0]   w_word;
    logic               w_stream_d;

    // A byte moves only when both sides agree; the 4th byte completes a word.
    assign w_accept    = in_valid && in_ready_q;
    assign w_word_done = w_accept && (byte_cnt_q == 2'd3);
    assign w_word      = {in_data, asm_q};

    // Next-state, byte assembly, write sequencing and registered-output decode.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        asm_d          = asm_q;
        entry_d        = entry_q;
        last_idx_d     = last_idx_q;
        word_idx_d     = word_idx_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wdata_d        = wdata_q;
        init_pc_d      = init_pc_q;
        w_stream_d     = 1'b0;
`ifdef CHECKSUM_EN
        sum_d          = sum_q;
`endif

        if (w_accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    asm_d[7:0]   = in_data;
                2'd1:    asm_d[15:8]  = in_data;
                2'd2:    asm_d[23:16] = in_data;
                default: asm_d        = asm_q;
            endcase
        end

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_d    = ST_HDR_PC;
                    byte_cnt_d = 2'd0;
                    asm_d      = '0;
                    word_idx_d = '0;
`ifdef CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            ST_HDR_PC: begin
                if (w_word_done) begin
                    entry_d = w_word;
                    state_d = (w_word[1:0] != 2'b00) ? ST_ERR : ST_HDR_LEN;
                end
            end
            ST_HDR_LEN: begin
                if (w_word_done) begin
                    // N == CAP truncates to 0, so N-1 wraps to CAP-1 as intended.
                    last_idx_d = w_word[IDX_W-1:0] - IDX_ONE;
                    if (w_word > CAP_W) begin
                        state_d = ST_ERR;
                    end else if (w_word == '0) begin
                        state_d = ST_POST;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_word_done) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {word_idx_q, 2'b00};
                    wdata_d   = w_word;
`ifdef CHECKSUM_EN
                    sum_d     = sum_q + w_word;
`endif
                    // Index stops at the last word so the address never wraps.
                    if (word_idx_q == last_idx_q) begin
                        state_d = ST_POST;
                    end else begin
                        word_idx_d = word_idx_q + IDX_ONE;
                    end
                end
            end
`ifdef CHECKSUM_EN
            ST_CHK: begin
                if (w_word_done) begin
                    state_d = (w_word == sum_q) ? ST_RUN : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        w_stream_d = (state_d == ST_HDR_PC) || (state_d == ST_HDR_LEN) ||
                     (state_d == ST_LOAD);
`ifdef CHECKSUM_EN
        if (state_d == ST_CHK) begin
            w_stream_d = 1'b1;
        end
`endif

        // Ready drops for one cycle after every completed word.
        in_ready_d     = w_stream_d && !w_word_done;
        busy_d         = w_stream_d;
        error_d        = (state_d == ST_ERR);
        // Release one cycle after RUN is entered, behind the last imem write.
        core_reset_n_d = (state_q == ST_RUN) && (state_d == ST_RUN);
        if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
            init_pc_d = entry_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= '0;
            asm_q          <= '0;
            entry_q        <= '0;
            last_idx_q     <= '0;
            word_idx_q     <= '0;
            in_ready_q     <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wdata_q        <= '0;
            core_reset_n_q <= 1'b0;
            init_pc_q      <= '0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            asm_q          <= asm_d;
            entry_q        <= entry_d;
            last_idx_q     <= last_idx_d;
            word_idx_q     <= word_idx_d;
            in_ready_q     <= in_ready_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wdata_q        <= wdata_d;
            core_reset_n_q <= core_reset_n_d;
            init_pc_q      <= init_pc_d;
            busy_q         <= busy_d;
            error_q        <= error_d;
`ifdef CHECKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wdata   = wdata_q;
    assign core_reset_n = core_reset_n_q;
    assign init_pc      = init_pc_q;
    assign busy         = busy_q;
    assign error        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_loader_ctrl
// Purpose  : Directed + randomized bench for boot_loader_ctrl. A session-level
//            model derives the expected imem writes, final status and entry PC
//            from the stream contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_loader_ctrl;

    localparam int IADDR = 10;
    localparam int CAP   = 256;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready;
    logic             imem_wr_en;
    logic [IADDR-1:0] imem_wr_addr;
    logic [31:0]      imem_wdata;
    logic             core_reset_n;
    logic [31:0]      init_pc;
    logic             busy;
    logic             error;

    boot_loader_ctrl #(.WIDTH(32), .IADDR(IADDR)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .init_pc      (init_pc),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lw_cyc  = -1;
    int          rel_cyc = -1;
    logic        prev_crn = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] pay[$];
    logic [31:0] last_pc = 32'h0;

    // Observe imem writes and the core release edge away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_wr_en) begin
            wr_addr_q.push_back(32'(imem_wr_addr));
            wr_data_q.push_back(imem_wdata);
            lw_cyc = cyc;
        end
        if (core_reset_n && !prev_crn && rel_cyc < 0) rel_cyc = cyc;
        prev_crn = core_reset_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        if (n_fail >= 40) begin
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit noise);
        int guard;
        guard = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                in_valid = 1'b0;
                start    = noise && ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        start    = noise && ($urandom_range(0, 3) == 0);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps, input bit noise);
        for (int i = 0; i < 4; i++) send_byte(8'((w >> (8 * i)) & 32'hFF), gaps, noise);
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back($urandom);
    endtask

    // One load session; pay[] holds the payload when N is within capacity.
    task automatic session(input logic [31:0] entry, input logic [31:0] n,
                           input bit gaps, input bit noise, input logic [31:0] delta);
        logic [31:0] sum;
        bit          hdr_err;
        bit          exp_err;
        int          exp_writes;
        sum     = 32'h0;
        hdr_err = (entry % 4 != 0) || (n > CAP);
        exp_err = hdr_err;
        wr_addr_q.delete();
        wr_data_q.delete();
        rel_cyc = -1;
        lw_cyc  = -1;
        pulse_start();
        send_word(entry, gaps, noise);
        if (entry % 4 == 0) begin
            send_word(n, gaps, noise);
            if (n <= CAP) begin
                foreach (pay[k]) begin
                    send_word(pay[k], gaps, noise);
                    sum = sum + pay[k];
                end
`ifdef CHECKSUM_EN
                send_word(sum + delta, gaps, noise);
                if (delta != 0) exp_err = 1'b1;
`endif
            end
        end
        repeat (4) @(negedge clk);
        exp_writes = hdr_err ? 0 : int'(n);
        check("wr_count", 32'(wr_data_q.size()), 32'(exp_writes));
        for (int k = 0; k < exp_writes && k < wr_data_q.size(); k++) begin
            check("wr_addr", wr_addr_q[k], 32'(4 * k));
            check("wr_data", wr_data_q[k], pay[k]);
        end
        if (!exp_err) last_pc = entry;
        check("busy_end",     32'(busy),         32'd0);
        check("in_ready_end", 32'(in_ready),     32'd0);
        check("error_end",    32'(error),        32'(exp_err));
        check("core_rst_end", 32'(core_reset_n), 32'(!exp_err));
        check("init_pc_end",  init_pc,           last_pc);
        if (!exp_err && n > 0) begin
`ifdef CHECKSUM_EN
            check("release_after_write", 32'(rel_cyc > lw_cyc), 32'd1);
`else
            check("release_gap", 32'(rel_cyc - lw_cyc), 32'd1);
`endif
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),     32'd0);
        check("rst_wr_en",     32'(imem_wr_en),   32'd0);
        check("rst_wr_addr",   32'(imem_wr_addr), 32'd0);
        check("rst_wdata",     imem_wdata,        32'd0);
        check("rst_core_rst",  32'(core_reset_n), 32'd0);
        check("rst_init_pc",   init_pc,           32'd0);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_error",     32'(error),        32'd0);

        // Basic two-word program, valid held high.
        pay.delete();
        pay.push_back(32'h00500093);
        pay.push_back(32'h00108113);
        session(32'h10, 32'd2, 1'b0, 1'b0, 32'd0);
`ifdef CHECKSUM_EN
        session(32'h10, 32'd2, 1'b0, 1'b0, 32'd1);
`endif

        // Misaligned entry, then recovery.
        pay.delete();
        session(32'h12, 32'd0, 1'b0, 1'b0, 32'd0);
        fill_random(5);
        session(32'h100, 32'd5, 1'b1, 1'b0, 32'd0);

        // Capacity boundaries and empty program.
        pay.delete();
        session(32'h40, 32'd257, 1'b1, 1'b0, 32'd0);
        fill_random(CAP);
        session(32'h0, 32'(CAP), 1'b0, 1'b0, 32'd0);
        pay.delete();
        session(32'h20, 32'd0, 1'b1, 1'b0, 32'd0);

        // Random gaps with spurious start pulses while busy.
        for (int it = 0; it < 4; it++) begin
            int n;
            n = $urandom_range(1, 12);
            fill_random(n);
            session($urandom & 32'hFFFF_FFFC, 32'(n), 1'b1, 1'b1, 32'd0);
        end

        // Reset in the middle of a load.
        wr_data_q.delete();
        wr_addr_q.delete();
        pulse_start();
        send_word(32'h80, 1'b0, 1'b0);
        send_word(32'd4, 1'b0, 1'b0);
        send_word(32'hDEADBEEF, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_wr_count", 32'(wr_data_q.size()), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_core_rst", 32'(core_reset_n), 32'd0);
        check("mid_init_pc",  init_pc,           32'd0);
        check("mid_busy",     32'(busy),         32'd0);
        check("mid_in_ready", 32'(in_ready),     32'd0);
        check("mid_error",    32'(error),        32'd0);
        reset_n = 1'b1;
        last_pc = 32'h0;

        fill_random(3);
        session(32'h44, 32'd3, 1'b1, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
